utopia_rx_collector: RTL and testbench
======================================

// Module: utopia_rx_collector
// PURPOSE
//  Parametrised N-port Utopia Level-1 receive front end for the squat switch.
//  - Polls each rx port's clav round-robin and reads one cell from the granted port.
//  - Buffers the cell and streams it to the switch core on a valid/ready byte stream,
//    tagged with the source port.
//  - Replaces per-port hard-wired rx logic; port count, cell size, data width are generics.
// PARAMETERS
//  NUM_PORTS   8    number of Utopia rx ports (1..16)
//  DATA_W      8    Utopia data bus width in bits
//  CELL_BYTES  53   words per cell (ATM UNI = 53)
//  PW          $clog2(NUM_PORTS) (min 1)  port-index width, derived
// PORTS
//  clk          in   1                 system clock, all logic rising-edge
//  rst_n        in   1                 asynchronous, active-low reset
//  port_enable  in   NUM_PORTS         1 = port may be polled; sampled at each arbitration
//  rx_clav      in   NUM_PORTS         PHY cell-available per port
//  rx_soc       in   NUM_PORTS         PHY start-of-cell per port
//  rx_data      in   NUM_PORTS*DATA_W  PHY data, port p at [p*DATA_W +: DATA_W]
//  rx_en_n      out  NUM_PORTS         active-low read enable per port (one-hot-low at most)
//  out_valid    out  1                 stream word valid
//  out_ready    in   1                 downstream accepts word when valid&ready
//  out_data     out  DATA_W            cell word
//  out_sop      out  1                 high on word 0 of cell
//  out_eop      out  1                 high on word CELL_BYTES-1
//  out_port     out  PW                source port of current cell, stable across whole cell
//  cell_cnt     out  16                good cells delivered (saturating)
//  err_cnt      out  16                dropped cells (saturating)
// BEHAVIOUR
//  - Reset (async, any state):
//    - state=IDLE, rr_ptr=0, rx_en_n=all 1, out_valid/sop/eop=0.
//    - out_data=0, out_port=0, cell_cnt=err_cnt=0; buffer contents don't-care.
//  - IDLE: req = rx_clav & port_enable.
//    - If req!=0: grant first set bit searching from rr_ptr upward with wrap; -> RECV.
//    - rr_ptr <= grant+1 (mod NUM_PORTS).
//    - req==0: stay; rr_ptr unchanged.
//  - RECV:
//    - rx_en_n[grant]=0 for exactly CELL_BYTES consecutive cycles, starting the cycle after the grant.
//    - Word i is sampled one cycle after its enable cycle (registered en, 1-cycle PHY latency).
//    - Word index counter 0..CELL_BYTES-1; words are written to the cell buffer.
//  - Framing check:
//    - rx_soc[grant]=0 at word 0, or rx_soc[grant]=1 at any word>0 -> cell marked bad.
//    - Enables still run to completion so the PHY stays aligned.
//    - At the end of the cell: err_cnt++ and return to IDLE; nothing is emitted.
//  - rx_clav changes during RECV are ignored (Utopia L1 cell-level handshake).
//  - SEND: entered the cycle after the last sample of a good cell.
//    - out_valid=1, out_port=grant.
//    - Word k presented until valid&ready, then k+1.
//    - sop at k=0, eop at k=CELL_BYTES-1.
//    - out_ready low holds data/sop/eop stable; there is no timeout.
//    - On the eop handshake: cell_cnt++, out_valid=0 next cycle, -> IDLE.
//  - No overlap: a new poll starts only in IDLE. Minimum cell period = 1 + CELL_BYTES + 1 + CELL_BYTES cycles.
//  - port_enable changes take effect at the next IDLE arbitration only; a cell in flight completes.
//  - Counters saturate at 16'hFFFF; they never wrap.
//  - Exactly one rx_en_n bit low at a time; none are low outside RECV.
// TESTING
//  1. Reset mid-RECV (rst_n low at word 20) -> rx_en_n all 1 and out_valid=0 immediately (async);
//     counters 0; first cell after release is received cleanly.
//  2. Port 3 only, clav=1, valid cell (soc on word 0, data 0..52), out_ready=1
//     -> rx_en_n[3] low 53 cycles; 53 words 0..52 out, sop/eop correct;
//     out_port=3; cell_cnt=1.
//  3. All 8 ports clav=1, rr_ptr=0 -> service order 0,1,...,7,0.
//     Only port 5 disabled -> order skips 5.
//  4. soc missing on word 0 of port 2 -> 53 enables still issued, no out_valid, err_cnt=1;
//     next port's cell delivered normally.
//  5. out_ready toggled 1/0 every cycle during SEND -> each word held until accepted, no loss/duplication;
//     SEND takes 106 cycles; no rx_en_n low during SEND.
//  6. Force err_cnt to 16'hFFFF then inject bad cell -> stays 16'hFFFF.

Source files
------------

// File: rtl/utopia_rx_collector.sv
// rtl/utopia_rx_collector.sv - N-port Utopia L1 rx poller; buffers one cell and streams it tagged with its port.
module utopia_rx_collector #(
  parameter int NUM_PORTS  = 8,
  parameter int DATA_W     = 8,
  parameter int CELL_BYTES = 53,
  parameter int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          port_enable,
  input  logic [NUM_PORTS-1:0]          rx_clav,
  input  logic [NUM_PORTS-1:0]          rx_soc,
  input  logic [NUM_PORTS*DATA_W-1:0]   rx_data,
  output logic [NUM_PORTS-1:0]          rx_en_n,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [PW-1:0]                 out_port,
  output logic [15:0]                   cell_cnt,
  output logic [15:0]                   err_cnt
);

  localparam int CW = (CELL_BYTES > 1) ? $clog2(CELL_BYTES) : 1;
  localparam logic [CW-1:0] LAST      = CW'(CELL_BYTES - 1);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {IDLE, RECV, SEND} state_t;

  state_t             state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      grant;
  logic [CW-1:0]      en_idx;
  logic [CW-1:0]      wr_idx;
  logic [CW-1:0]      rd_idx;
  logic [CW-1:0]      rd_nxt;
  logic               samp_v;
  logic               bad;
  logic [DATA_W-1:0]  cell_buf [CELL_BYTES];

  logic [NUM_PORTS-1:0] req;
  logic [PW-1:0]        pick;
  logic                 pick_v;
  logic [DATA_W-1:0]    rx_word;
  logic                 soc_g;
  logic                 soc_err;

  assign req     = rx_clav & port_enable;
  assign rx_word = rx_data[grant*DATA_W +: DATA_W];
  assign soc_g   = rx_soc[grant];
  assign soc_err = (wr_idx == '0) ? ~soc_g : soc_g;
  assign rd_nxt  = rd_idx + 1'b1;

  // First requesting port at or after rr_ptr, wrapping around.
  always_comb begin
    pick   = '0;
    pick_v = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!pick_v && req[(int'(rr_ptr) + i) % NUM_PORTS]) begin
        pick   = PW'((int'(rr_ptr) + i) % NUM_PORTS);
        pick_v = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      en_idx    <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      samp_v    <= 1'b0;
      bad       <= 1'b0;
      rx_en_n   <= '1;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
      cell_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      // The PHY answers an enable one cycle later, so sampling trails the enables.
      samp_v <= ~&rx_en_n;
      case (state)
        IDLE: begin
          if (pick_v) begin
            grant    <= pick;
            out_port <= pick;
            rr_ptr   <= (pick == LAST_PORT) ? '0 : pick + 1'b1;
            rx_en_n  <= ~(NUM_PORTS'(1) << pick);
            en_idx   <= '0;
            wr_idx   <= '0;
            bad      <= 1'b0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (!(&rx_en_n)) begin
            if (en_idx == LAST) rx_en_n <= '1;
            else                en_idx  <= en_idx + 1'b1;
          end
          if (samp_v) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == LAST) begin
              if (bad || soc_err) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                state <= IDLE;
              end else begin
                out_valid <= 1'b1;
                out_sop   <= 1'b1;
                out_eop   <= (LAST == '0);
                out_data  <= (wr_idx == '0) ? rx_word : cell_buf[0];
                rd_idx    <= '0;
                state     <= SEND;
              end
            end else begin
              bad <= bad | soc_err;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            if (rd_idx == LAST) begin
              out_valid <= 1'b0;
              out_sop   <= 1'b0;
              out_eop   <= 1'b0;
              if (cell_cnt != 16'hFFFF) cell_cnt <= cell_cnt + 16'd1;
              state     <= IDLE;
            end else begin
              rd_idx   <= rd_nxt;
              out_data <= cell_buf[rd_nxt];
              out_sop  <= 1'b0;
              out_eop  <= (rd_nxt == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RECV && samp_v) cell_buf[wr_idx] <= rx_word;
  end

endmodule

// File: tb/tb_utopia_rx_collector.sv
// tb/tb_utopia_rx_collector.sv - directed bench: reset, single port, round robin, framing error, backpressure, saturation.
module tb_utopia_rx_collector;

  localparam int NP = 8;
  localparam int DW = 8;
  localparam int CB = 53;
  localparam int PW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     port_enable = '1;
  logic [NP-1:0]     rx_clav = '0;
  logic [NP-1:0]     rx_soc = '0;
  logic [NP*DW-1:0]  rx_data = '0;
  logic [NP-1:0]     rx_en_n;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_data;
  logic              out_sop;
  logic              out_eop;
  logic [PW-1:0]     out_port;
  logic [15:0]       cell_cnt;
  logic [15:0]       err_cnt;

  utopia_rx_collector #(.NUM_PORTS(NP), .DATA_W(DW), .CELL_BYTES(CB)) dut (
    .clk(clk), .rst_n(rst_n), .port_enable(port_enable), .rx_clav(rx_clav),
    .rx_soc(rx_soc), .rx_data(rx_data), .rx_en_n(rx_en_n), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_port(out_port), .cell_cnt(cell_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int bad_port = -1;
  int phy_idx [NP];
  logic [NP-1:0] en_neg = '1;
  int en_cycles [NP];
  int multi_low = 0, en_in_send = 0, valid_cycles = 0, hold_viol = 0, cells_seen = 0;
  logic [DW-1:0] q_data [$];
  logic          q_sop [$];
  logic          q_eop [$];
  logic [PW-1:0] q_port [$];
  logic          prev_stall = 1'b0;
  logic [DW+PW+1:0] prev_out = '0;

  // PHY model: a word (its index in the cell) appears the cycle after each enable.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) begin
      if (!rst_n) begin
        phy_idx[p] = 0;
        rx_soc[p] = 1'b0;
      end else if (!en_neg[p]) begin
        rx_data[p*DW +: DW] = 8'(phy_idx[p]);
        rx_soc[p] = (phy_idx[p] == 0) && (p != bad_port);
        phy_idx[p] = (phy_idx[p] == CB-1) ? 0 : phy_idx[p] + 1;
      end else begin
        rx_soc[p] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    en_neg = rx_en_n;
    for (int p = 0; p < NP; p++) if (!rx_en_n[p]) en_cycles[p]++;
    if ($countones(~rx_en_n) > 1) multi_low++;
    if (out_valid && rx_en_n != '1) en_in_send++;
    if (out_valid) valid_cycles++;
    if (prev_stall && {out_data, out_sop, out_eop, out_port} != prev_out) hold_viol++;
    prev_stall = out_valid && !out_ready;
    prev_out = {out_data, out_sop, out_eop, out_port};
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_sop.push_back(out_sop);
      q_eop.push_back(out_eop);
      q_port.push_back(out_port);
      if (out_eop) cells_seen++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cells(input int target, input int budget, input string name);
    int n = 0;
    while (cells_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cells_seen < target) begin
      errors++;
      $display("FAIL %s_timeout: cells=%0d required=%0d", name, cells_seen, target);
    end
  endtask

  task automatic test_reset();
    int e0, n;
    rx_clav = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rx_en_n !== 8'hFF) begin errors++; $display("FAIL rst_en: got=%h exp=ff", rx_en_n); end
    checks++; if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin errors++; $display("FAIL rst_flags: got=%b%b%b exp=000", out_valid, out_sop, out_eop); end
    checks++; if (out_data !== 8'h00 || out_port !== 3'd0) begin errors++; $display("FAIL rst_data: got=%h/%0d exp=00/0", out_data, out_port); end
    checks++; if (cell_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got=%0d/%0d exp=0/0", cell_cnt, err_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    e0 = en_cycles[3];
    rx_clav = 8'h08;
    n = 0;
    while (en_cycles[3] - e0 < 20 && n < 60) begin @(negedge clk); n++; end
    checks++; if (en_cycles[3] - e0 < 20) begin errors++; $display("FAIL midrecv_timeout: en=%0d exp=20", en_cycles[3] - e0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rx_en_n !== 8'hFF) begin errors++; $display("FAIL async_rst_en: got=%h exp=ff", rx_en_n); end
    checks++; if (out_valid !== 1'b0 || cell_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_state: got=%b/%0d/%0d exp=0/0/0", out_valid, cell_cnt, err_cnt); end
    rx_clav = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_port();
    int qs, e0, c0, ml0, bad_d, bad_f, bad_p;
    qs = q_data.size(); e0 = en_cycles[3]; c0 = cells_seen; ml0 = multi_low;
    out_ready = 1'b1;
    rx_clav = 8'h08;
    wait_cells(c0 + 1, 400, "single");
    rx_clav = '0;
    repeat (3) @(negedge clk);
    checks++; if (en_cycles[3] - e0 != CB) begin errors++; $display("FAIL single_enables: got=%0d exp=%0d", en_cycles[3] - e0, CB); end
    checks++; if (q_data.size() - qs != CB) begin errors++; $display("FAIL single_words: got=%0d exp=%0d", q_data.size() - qs, CB); end
    bad_d = 0; bad_f = 0; bad_p = 0;
    for (int i = 0; i < CB && qs + i < q_data.size(); i++) begin
      if (q_data[qs+i] !== 8'(i)) bad_d++;
      if (q_sop[qs+i] !== (i == 0) || q_eop[qs+i] !== (i == CB-1)) bad_f++;
      if (q_port[qs+i] !== 3'd3) bad_p++;
    end
    checks++; if (bad_d != 0) begin errors++; $display("FAIL single_data: bad_words=%0d exp=0", bad_d); end
    checks++; if (bad_f != 0) begin errors++; $display("FAIL single_sop_eop: bad_words=%0d exp=0", bad_f); end
    checks++; if (bad_p != 0) begin errors++; $display("FAIL single_port: bad_words=%0d exp=0", bad_p); end
    checks++; if (cell_cnt !== 16'd1) begin errors++; $display("FAIL single_cell_cnt: got=%0d exp=1", cell_cnt); end
    checks++; if (multi_low != ml0) begin errors++; $display("FAIL single_onehot: got=%0d exp=0", multi_low - ml0); end
  endtask

  task automatic rr_run(input logic [NP-1:0] en_mask, input int exp_order[9], input int ncells, input string name);
    int qs, c0, k;
    int got [9];
    do_reset();
    qs = q_data.size(); c0 = cells_seen;
    port_enable = en_mask;
    rx_clav = '1;
    wait_cells(c0 + ncells, ncells * 120 + 50, name);
    rx_clav = '0;
    port_enable = '1;
    repeat (3) @(negedge clk);
    k = 0;
    for (int i = qs; i < q_data.size(); i++) begin
      if (q_sop[i] && k < 9) begin got[k] = int'(q_port[i]); k++; end
    end
    checks++; if (k != ncells) begin errors++; $display("FAIL %s_count: got=%0d exp=%0d", name, k, ncells); end
    for (int i = 0; i < ncells && i < k; i++) begin
      checks++;
      if (got[i] != exp_order[i]) begin errors++; $display("FAIL %s_order[%0d]: got=%0d exp=%0d", name, i, got[i], exp_order[i]); end
    end
  endtask

  task automatic test_round_robin();
    int all_on [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int skip5 [9] = '{0, 1, 2, 3, 4, 6, 7, 0, 1};
    rr_run(8'hFF, all_on, 9, "rr_all");
    rr_run(8'hDF, skip5, 8, "rr_skip5");
  endtask

  task automatic test_bad_soc();
    int qs, e0, c0, bad_p;
    do_reset();
    qs = q_data.size(); e0 = en_cycles[2]; c0 = cells_seen;
    bad_port = 2;
    rx_clav = 8'h0C;
    wait_cells(c0 + 1, 400, "badsoc");
    rx_clav = '0;
    bad_port = -1;
    repeat (3) @(negedge clk);
    checks++; if (en_cycles[2] - e0 != CB) begin errors++; $display("FAIL badsoc_enables: got=%0d exp=%0d", en_cycles[2] - e0, CB); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL badsoc_err_cnt: got=%0d exp=1", err_cnt); end
    checks++; if (cell_cnt !== 16'd1) begin errors++; $display("FAIL badsoc_cell_cnt: got=%0d exp=1", cell_cnt); end
    bad_p = 0;
    for (int i = qs; i < q_data.size(); i++) if (q_port[i] !== 3'd3 || q_data[i] !== 8'(i - qs)) bad_p++;
    checks++; if (bad_p != 0 || q_data.size() - qs != CB) begin errors++; $display("FAIL badsoc_next_cell: bad=%0d words=%0d exp=0/%0d", bad_p, q_data.size() - qs, CB); end
  endtask

  task automatic test_backpressure();
    int qs, c0, v0, es0, h0, n, bad_d;
    do_reset();
    qs = q_data.size(); c0 = cells_seen; v0 = valid_cycles; es0 = en_in_send; h0 = hold_viol;
    out_ready = 1'b0;
    rx_clav = 8'h02;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    rx_clav = '0;
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_send_timeout: out_valid=%b exp=1", out_valid); end
    n = 0;
    while (cells_seen < c0 + 1 && n < 400) begin
      @(posedge clk);
      #1 out_ready = ~out_ready;
      n++;
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cells_seen < c0 + 1) begin errors++; $display("FAIL bp_timeout: cells=%0d exp=%0d", cells_seen, c0 + 1); end
    bad_d = 0;
    for (int i = 0; i < CB && qs + i < q_data.size(); i++) if (q_data[qs+i] !== 8'(i)) bad_d++;
    checks++; if (bad_d != 0 || q_data.size() - qs != CB) begin errors++; $display("FAIL bp_words: bad=%0d words=%0d exp=0/%0d", bad_d, q_data.size() - qs, CB); end
    checks++; if (hold_viol != h0) begin errors++; $display("FAIL bp_hold: changes=%0d exp=0", hold_viol - h0); end
    checks++; if (valid_cycles - v0 != 2*CB) begin errors++; $display("FAIL bp_send_cycles: got=%0d exp=%0d", valid_cycles - v0, 2*CB); end
    checks++; if (en_in_send != es0) begin errors++; $display("FAIL bp_en_in_send: got=%0d exp=0", en_in_send - es0); end
  endtask

  task automatic test_err_saturate();
    int e0, n, qs;
    do_reset();
    force dut.err_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.err_cnt;
    @(negedge clk);
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_preload: got=%h exp=ffff", err_cnt); end
    qs = q_data.size(); e0 = en_cycles[4];
    bad_port = 4;
    rx_clav = 8'h10;
    n = 0;
    while (en_cycles[4] - e0 < CB && n < 200) begin @(negedge clk); n++; end
    rx_clav = '0;
    repeat (6) @(negedge clk);
    bad_port = -1;
    checks++; if (en_cycles[4] - e0 != CB) begin errors++; $display("FAIL sat_enables: got=%0d exp=%0d", en_cycles[4] - e0, CB); end
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_err_cnt: got=%h exp=ffff", err_cnt); end
    checks++; if (cell_cnt !== 16'd0 || q_data.size() != qs) begin errors++; $display("FAIL sat_no_emit: cells=%0d words=%0d exp=0/0", cell_cnt, q_data.size() - qs); end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_bad_soc();
    test_backpressure();
    test_err_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
